// File: rtl/cpu_mem_responder_if.sv
// CPU-side request/response bus between the Tron core and the memory responder.
// master = CPU (drives requests), slave = responder (drives status and results).
interface cpu_mem_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req;
  logic              fetch;
  logic              we;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              ack;
  logic [DATA_W-1:0] instruction;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output req, fetch, we, pc, data_addr, wdata,
    input  ready, ack, instruction, mem_data
  );

  modport slave (
    input  req, fetch, we, pc, data_addr, wdata,
    output ready, ack, instruction, mem_data
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for Tron: sequences a synchronous single-port RAM for
// fetch/load/store requests and owns the memory-mapped LED register.
//
// state | meaning
// IDLE  | waiting for a request
// WRITE | RAM write enable high for one cycle
// READ  | waiting out RAM read latency, then capture
// LEDRD | copying LED register into mem_data
// DONE  | ack pulse; may accept the next request
module cpu_mem_responder #(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 16,
  parameter int              RD_LAT   = 1,
  parameter logic [ADDR_W-1:0] LED_ADDR = {ADDR_W{1'b1}}
) (
  input  logic                clk,
  input  logic                reset,
  cpu_mem_responder_if.slave  bus,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic                ram_we,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [15:0]         LED
);

  localparam int CNT_W = 3;

  typedef enum logic [2:0] {IDLE, WRITE, READ, LEDRD, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt;
  logic                is_fetch;
  logic [DATA_W-1:0]   instr_q;
  logic [DATA_W-1:0]   mdata_q;
  logic                ready;
  logic                ack;
  logic [ADDR_W-1:0]   addr_sel;
  logic                is_store;
  logic                is_led;
  logic                accept;

  always_comb begin
    addr_sel = bus.fetch ? bus.pc : bus.data_addr;
    is_store = ~bus.fetch & bus.we;
    // Only data accesses decode the LED address; fetches always go to RAM.
    is_led   = ~bus.fetch & (addr_sel == LED_ADDR);
    accept   = bus.req & ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (is_store && is_led) state_d = DONE;
          else if (is_store)      state_d = WRITE;
          else if (is_led)        state_d = LEDRD;
          else                    state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE, LEDRD: state_d = DONE;
      READ:         if (cnt == '0) state_d = DONE;
      default:      state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == IDLE) || (state_q == DONE);
    ack   = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      is_fetch  <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      LED       <= '0;
      instr_q   <= '0;
      mdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            is_fetch <= bus.fetch;
            cnt      <= CNT_W'(RD_LAT);
            ram_we   <= is_store & ~is_led;
            if (is_store && is_led) begin
              LED <= 16'(bus.wdata);
            end else if (!is_led) begin
              ram_addr <= addr_sel;
              if (is_store) ram_wdata <= bus.wdata;
            end
          end
        end
        WRITE: ram_we <= 1'b0;
        LEDRD: mdata_q <= DATA_W'(LED);
        READ: begin
          // RAM sampled the address on the first READ edge; terminal count
          // means its data is now stable.
          if (cnt == '0) begin
            if (is_fetch) instr_q <= ram_rdata;
            else          mdata_q <= ram_rdata;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready       = ready;
  assign bus.ack         = ack;
  assign bus.instruction = instr_q;
  assign bus.mem_data    = mdata_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed scenarios plus random
// traffic against a transaction-level model of memory, LED and outputs.
module tb_cpu_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  cpu_mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus1();
  cpu_mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus3();

  logic [15:0] ram_addr1, ram_wdata1, ram_rdata1, led1;
  logic        ram_we1;
  logic [15:0] ram_addr3, ram_wdata3, ram_rdata3, led3;
  logic        ram_we3;

  cpu_mem_responder #(.RD_LAT(1)) dut1 (
    .clk(clk), .reset(rst), .bus(bus1.slave),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_we(ram_we1),
    .ram_rdata(ram_rdata1), .LED(led1)
  );

  cpu_mem_responder #(.RD_LAT(3)) dut3 (
    .clk(clk), .reset(rst), .bus(bus3.slave),
    .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_we(ram_we3),
    .ram_rdata(ram_rdata3), .LED(led3)
  );

  // RAM environments: latency 1 and latency 3, read-before-write.
  logic [15:0] mem1 [0:65535];
  logic [15:0] mem3 [0:65535];
  logic [15:0] p0, p1;

  always @(posedge clk) begin
    ram_rdata1 <= mem1[ram_addr1];
    if (ram_we1) mem1[ram_addr1] = ram_wdata1;
  end

  always @(posedge clk) begin
    p0         <= mem3[ram_addr3];
    p1         <= p0;
    ram_rdata3 <= p1;
    if (ram_we3) mem3[ram_addr3] = ram_wdata3;
  end

  // Reference model state
  logic [15:0] ref_mem [0:65535];
  logic [15:0] ref_led, ref_instr, ref_mdata, ref_ram_addr;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic ref_reset();
    ref_led = 0; ref_instr = 0; ref_mdata = 0; ref_ram_addr = 0;
  endtask

  task automatic ref_apply(input logic f, input logic w, input logic [15:0] a,
                           input logic [15:0] d, output int lat, output int wes);
    logic store, led;
    store = !f && w;
    led   = !f && (a == 16'hFFFF);
    wes   = 0;
    if (store && led) begin
      ref_led = d; lat = 0;
    end else if (store) begin
      ref_mem[a] = d; ref_ram_addr = a; lat = 1; wes = 1;
    end else if (led) begin
      ref_mdata = ref_led; lat = 1;
    end else begin
      ref_ram_addr = a; lat = 2;
      if (f) ref_instr = ref_mem[a];
      else   ref_mdata = ref_mem[a];
    end
  endtask

  // One request on dut1; inputs scrambled right after the accept edge.
  task automatic run1(input logic f, input logic w, input logic [15:0] a, input logic [15:0] d,
                      output int lat, output int wecnt, output int acks, output logic [15:0] ra0);
    @(negedge clk);
    bus1.req = 1; bus1.fetch = f; bus1.we = w; bus1.wdata = d;
    bus1.pc        = f ? a : 16'($urandom);
    bus1.data_addr = f ? 16'($urandom) : a;
    @(posedge clk);
    #1;
    bus1.req = 0; bus1.fetch = 1'($urandom); bus1.we = 1'($urandom);
    bus1.pc = 16'($urandom); bus1.data_addr = 16'($urandom); bus1.wdata = 16'($urandom);
    lat = -1; wecnt = 0; acks = 0; ra0 = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) ra0 = ram_addr1;
      if (ram_we1) wecnt++;
      if (bus1.ack) begin
        acks++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (bus1.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus1.ready); end
    checks++; if (bus1.ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bus1.ack); end
    checks++; if (ram_we1 !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b expected 0", ram_we1); end
    checks++; if ({bus1.instruction, bus1.mem_data, ram_addr1, ram_wdata1, led1} !== 80'h0) begin
      errors++; $display("FAIL reset_regs: got %h %h %h %h %h expected all 0",
                         bus1.instruction, bus1.mem_data, ram_addr1, ram_wdata1, led1);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++; if (bus1.ready !== 1'b1 || bus1.ack !== 1'b0 || bus3.ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle: got ready=%b ack=%b ready3=%b expected 1 0 1",
                         bus1.ready, bus1.ack, bus3.ready);
    end
  endtask

  task automatic test_fetch_basic();
    int lat, wec, acks, elat, ewe; logic [15:0] ra0;
    run1(1'b1, 1'b0, 16'h0010, 16'h0, lat, wec, acks, ra0);
    ref_apply(1'b1, 1'b0, 16'h0010, 16'h0, elat, ewe);
    checks++; if (ra0 !== 16'h0010) begin errors++; $display("FAIL fetch_ram_addr: got %h expected 0010", ra0); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL fetch_latency: got %0d expected 2", lat); end
    checks++; if (bus1.instruction !== 16'hA5C3) begin errors++; $display("FAIL fetch_instr: got %h expected a5c3", bus1.instruction); end
    checks++; if (bus1.mem_data !== 16'h0000) begin errors++; $display("FAIL fetch_mem_data: got %h expected 0000", bus1.mem_data); end
    checks++; if (acks !== 1) begin errors++; $display("FAIL fetch_acks: got %0d expected 1", acks); end
  endtask

  task automatic test_store_load();
    int lat, wec, acks, elat, ewe; logic [15:0] ra0;
    run1(1'b0, 1'b1, 16'h0020, 16'h1234, lat, wec, acks, ra0);
    ref_apply(1'b0, 1'b1, 16'h0020, 16'h1234, elat, ewe);
    checks++; if (wec !== 1) begin errors++; $display("FAIL store_we_cycles: got %0d expected 1", wec); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL store_latency: got %0d expected 1", lat); end
    checks++; if (mem1[16'h0020] !== 16'h1234) begin errors++; $display("FAIL store_ram: got %h expected 1234", mem1[16'h0020]); end
    run1(1'b0, 1'b0, 16'h0020, 16'h0, lat, wec, acks, ra0);
    ref_apply(1'b0, 1'b0, 16'h0020, 16'h0, elat, ewe);
    checks++; if (bus1.mem_data !== 16'h1234) begin errors++; $display("FAIL load_data: got %h expected 1234", bus1.mem_data); end
    checks++; if (lat !== 2 || wec !== 0) begin errors++; $display("FAIL load_timing: got lat=%0d we=%0d expected 2 0", lat, wec); end
    checks++; if (bus1.instruction !== ref_instr) begin errors++; $display("FAIL load_instr_held: got %h expected %h", bus1.instruction, ref_instr); end
  endtask

  task automatic test_led();
    int lat, wec, acks, elat, ewe; logic [15:0] ra0;
    run1(1'b0, 1'b1, 16'hFFFF, 16'h00FF, lat, wec, acks, ra0);
    ref_apply(1'b0, 1'b1, 16'hFFFF, 16'h00FF, elat, ewe);
    checks++; if (led1 !== 16'h00FF) begin errors++; $display("FAIL led_store: got %h expected 00ff", led1); end
    checks++; if (wec !== 0) begin errors++; $display("FAIL led_store_we: got %0d expected 0", wec); end
    checks++; if (lat !== 0) begin errors++; $display("FAIL led_store_latency: got %0d expected 0", lat); end
    checks++; if (ra0 !== ref_ram_addr) begin errors++; $display("FAIL led_ram_addr_held: got %h expected %h", ra0, ref_ram_addr); end
    run1(1'b0, 1'b0, 16'hFFFF, 16'h0, lat, wec, acks, ra0);
    ref_apply(1'b0, 1'b0, 16'hFFFF, 16'h0, elat, ewe);
    checks++; if (bus1.mem_data !== 16'h00FF) begin errors++; $display("FAIL led_load: got %h expected 00ff", bus1.mem_data); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL led_load_latency: got %0d expected 1", lat); end
    run1(1'b1, 1'b0, 16'hFFFF, 16'h0, lat, wec, acks, ra0);
    ref_apply(1'b1, 1'b0, 16'hFFFF, 16'h0, elat, ewe);
    checks++; if (bus1.instruction !== ref_instr || lat !== 2) begin
      errors++; $display("FAIL fetch_led_addr: got %h lat %0d expected %h lat 2", bus1.instruction, lat, ref_instr);
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0, last = -1, idx = 0;
    @(negedge clk);
    bus1.req = 1; bus1.fetch = 1; bus1.we = 0; bus1.pc = 16'h0000;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus1.ack) begin
        acks++;
        checks++; if (bus1.ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done: got %b expected 1", bus1.ready); end
        checks++; if (idx < 3 && bus1.instruction !== ref_mem[idx]) begin
          errors++; $display("FAIL b2b_instr%0d: got %h expected %h", idx, bus1.instruction, ref_mem[idx]);
        end
        if (last >= 0) begin
          checks++; if (c - last !== 3) begin errors++; $display("FAIL b2b_spacing: got %0d expected 3", c - last); end
        end
        last = c;
        idx++;
        if (idx < 3) bus1.pc = 16'(idx);
        else bus1.req = 0;
      end
    end
    bus1.req = 0;
    checks++; if (acks !== 3) begin errors++; $display("FAIL b2b_ack_count: got %0d expected 3", acks); end
    ref_instr = ref_mem[2]; ref_ram_addr = 16'h0002;
  endtask

  task automatic test_rd_lat3();
    int lat = -1, acks = 0;
    @(negedge clk);
    bus3.req = 1; bus3.fetch = 0; bus3.we = 0; bus3.data_addr = 16'h0007; bus3.pc = 16'h0;
    @(posedge clk);
    #1 bus3.req = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus3.ack) begin
        acks++;
        if (lat < 0) lat = k;
      end
      if (k <= 3) begin
        checks++; if (bus3.ready !== 1'b0) begin errors++; $display("FAIL lat3_busy_ready k%0d: got %b expected 0", k, bus3.ready); end
        bus3.req = 1'($urandom); bus3.fetch = 1'($urandom);
        bus3.pc = 16'($urandom); bus3.data_addr = 16'($urandom);
      end else begin
        bus3.req = 0;
      end
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL lat3_latency: got %0d expected 4", lat); end
    checks++; if (acks !== 1) begin errors++; $display("FAIL lat3_acks: got %0d expected 1", acks); end
    checks++; if (bus3.mem_data !== init_val(16'h0007)) begin errors++; $display("FAIL lat3_data: got %h expected %h", bus3.mem_data, init_val(16'h0007)); end
    checks++; if (bus3.instruction !== 16'h0) begin errors++; $display("FAIL lat3_instr: got %h expected 0000", bus3.instruction); end
  endtask

  task automatic test_reset_mid();
    int lat, wec, acks, elat, ewe; logic [15:0] ra0;
    @(negedge clk);
    bus1.req = 1; bus1.fetch = 0; bus1.we = 0; bus1.data_addr = 16'h0010;
    @(posedge clk);
    #1 bus1.req = 0;
    @(negedge clk);
    rst = 1;
    #1;
    checks++; if (bus1.ready !== 1'b1 || bus1.ack !== 1'b0 || ram_we1 !== 1'b0) begin
      errors++; $display("FAIL midread_ctrl: got ready=%b ack=%b we=%b expected 1 0 0", bus1.ready, bus1.ack, ram_we1);
    end
    checks++; if ({bus1.instruction, bus1.mem_data, ram_addr1, led1} !== 64'h0) begin
      errors++; $display("FAIL midread_regs: got %h %h %h %h expected all 0", bus1.instruction, bus1.mem_data, ram_addr1, led1);
    end
    ref_reset();
    @(negedge clk);
    rst = 0;
    acks = 0;
    repeat (6) begin @(negedge clk); if (bus1.ack) acks++; end
    checks++; if (acks !== 0) begin errors++; $display("FAIL midread_no_ack: got %0d expected 0", acks); end
    // Store aborted while the write strobe is up must not reach RAM.
    @(negedge clk);
    bus1.req = 1; bus1.fetch = 0; bus1.we = 1; bus1.data_addr = 16'h0030; bus1.wdata = 16'hDEAD;
    @(posedge clk);
    #1 bus1.req = 0;
    @(negedge clk);
    checks++; if (ram_we1 !== 1'b1) begin errors++; $display("FAIL midwrite_we_before: got %b expected 1", ram_we1); end
    rst = 1;
    #1;
    checks++; if (ram_we1 !== 1'b0) begin errors++; $display("FAIL midwrite_we_drop: got %b expected 0", ram_we1); end
    @(negedge clk);
    rst = 0;
    ref_reset();
    run1(1'b0, 1'b0, 16'h0030, 16'h0, lat, wec, acks, ra0);
    ref_apply(1'b0, 1'b0, 16'h0030, 16'h0, elat, ewe);
    checks++; if (bus1.mem_data !== ref_mdata) begin errors++; $display("FAIL midwrite_ram_intact: got %h expected %h", bus1.mem_data, ref_mdata); end
  endtask

  task automatic test_random();
    int lat, wec, acks, elat, ewe, op; logic [15:0] ra0, a, d; logic f, w;
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 2));
      a  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 31));
      d  = 16'($urandom);
      f  = (op == 0);
      w  = (op == 2);
      run1(f, w, a, d, lat, wec, acks, ra0);
      ref_apply(f, w, a, d, elat, ewe);
      checks++;
      if (lat !== elat || wec !== ewe || acks !== 1 || ra0 !== ref_ram_addr) begin
        errors++; $display("FAIL rand%0d_timing op=%0d a=%h: got lat=%0d we=%0d acks=%0d ra=%h expected %0d %0d 1 %h",
                           i, op, a, lat, wec, acks, ra0, elat, ewe, ref_ram_addr);
      end
      checks++;
      if (bus1.instruction !== ref_instr || bus1.mem_data !== ref_mdata || led1 !== ref_led) begin
        errors++; $display("FAIL rand%0d_data op=%0d a=%h: got i=%h m=%h led=%h expected %h %h %h",
                           i, op, a, bus1.instruction, bus1.mem_data, led1, ref_instr, ref_mdata, ref_led);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    bus1.req = 0; bus1.fetch = 0; bus1.we = 0; bus1.pc = 0; bus1.data_addr = 0; bus1.wdata = 0;
    bus3.req = 0; bus3.fetch = 0; bus3.we = 0; bus3.pc = 0; bus3.data_addr = 0; bus3.wdata = 0;
    for (int i = 0; i < 65536; i++) begin
      mem1[i]    = init_val(16'(i));
      mem3[i]    = init_val(16'(i));
      ref_mem[i] = init_val(16'(i));
    end
    mem1[16'h0010]    = 16'hA5C3;
    ref_mem[16'h0010] = 16'hA5C3;
    ref_reset();
    #1;
    test_reset();
    test_fetch_basic();
    test_store_load();
    test_led();
    test_back_to_back();
    test_rd_lat3();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
